cordic_output_buffer: RTL and testbench

Parametrised output stage for the CORDIC datapath. It captures each finished result (X, Y) on the `done` pulse into a small FIFO. It then streams the result onto the system bus through a valid/ready handshake, as X only, Y only, or X followed by Y. Results are no longer lost when the bus is busy: back-pressure is absorbed up to DEPTH results, and overflow is flagged.

---
 rtl/cordic_output_buffer.sv | 154 +++++++++++++++
 tb/tb_cordic_output_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_output_buffer.sv
// Output stage for the CORDIC datapath: buffers finished (X, Y) results in a FIFO and streams them as bus words.
// Optional feature: define CORDIC_OUT_DROPCNT_EN to add the drop_count port and its saturating counter.
module cordic_output_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             done,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic [WIDTH-1:0] bus_data_out,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             fifo_full,
    output logic             overflow
`ifdef CORDIC_OUT_DROPCNT_EN
    ,
    output logic [7:0]       drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [1:0]  MODE_Y    = 2'b01;
    localparam logic [1:0]  MODE_PAIR = 2'b10;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        BEAT_A = 2'b01,
        BEAT_B = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] x_mem    [DEPTH];
    logic [WIDTH-1:0] y_mem    [DEPTH];
    logic [1:0]       mode_mem [DEPTH];

    logic [AW:0]      wr_ptr, rd_ptr, count, count_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic             pair_q, pair_nxt;
    logic             advance, pop, push, drop, fifo_empty;
    logic [WIDTH-1:0] head_x, head_y;
    logic [1:0]       head_mode;

    assign fifo_empty   = (count == '0);
    assign head_x       = x_mem[rd_ptr[AW-1:0]];
    assign head_y       = y_mem[rd_ptr[AW-1:0]];
    assign head_mode    = mode_mem[rd_ptr[AW-1:0]];
    assign bus_valid    = (state != EMPTY);
    assign bus_data_out = data_q;

    // bus_valid comes only from state, so bus_ready never reaches it combinationally
    assign advance = (state == EMPTY) || bus_ready;

    // pair_q marks a BEAT_A word whose Y half is still waiting at the FIFO head
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        pair_nxt  = pair_q;
        pop       = 1'b0;
        if (advance) begin
            if ((state == BEAT_A) && pair_q) begin
                state_nxt = BEAT_B;
                data_nxt  = head_y;
                pair_nxt  = 1'b0;
                pop       = 1'b1;
            end else if (!fifo_empty) begin
                state_nxt = BEAT_A;
                data_nxt  = (head_mode == MODE_Y) ? head_y : head_x;
                pair_nxt  = (head_mode == MODE_PAIR);
                pop       = (head_mode != MODE_PAIR);
            end else begin
                state_nxt = EMPTY;
                data_nxt  = '0;
                pair_nxt  = 1'b0;
            end
        end
    end

    // A pop on the same edge frees the slot, so a full FIFO can still accept
    always_comb begin
        push      = done && !clear && ((count != CNT_FULL) || pop);
        drop      = done && !clear && (count == CNT_FULL) && !pop;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            x_mem[wr_ptr[AW-1:0]]    <= X;
            y_mem[wr_ptr[AW-1:0]]    <= Y;
            mode_mem[wr_ptr[AW-1:0]] <= mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            data_q    <= '0;
            pair_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= EMPTY;
            data_q    <= '0;
            pair_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_q    <= data_nxt;
            pair_q    <= pair_nxt;
            count     <= count_nxt;
            fifo_full <= (count_nxt == CNT_FULL);
            if (push) begin
                wr_ptr <= wr_ptr + CNT_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef CORDIC_OUT_DROPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'd0;
        end else if (clear) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cordic_output_buffer.sv
// Self-checking bench for cordic_output_buffer: queue-based result model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cordic_output_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] x, y;
    logic             done;
    logic [1:0]       mode;
    logic             clear;
    logic [WIDTH-1:0] bus_data_out;
    logic             bus_valid;
    logic             bus_ready;
    logic             fifo_full;
    logic             overflow;
`ifdef CORDIC_OUT_DROPCNT_EN
    logic [7:0]       drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    cordic_output_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .X           (x),
        .Y           (y),
        .done        (done),
        .mode        (mode),
        .clear       (clear),
        .bus_data_out(bus_data_out),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
`ifdef CORDIC_OUT_DROPCNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of whole results; the head stays queued until its last word is on the bus
    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [1:0]       mode;
    } entry_t;

    entry_t           q[$];
    entry_t           new_e;
    int               head_taken = 0;
    logic             m_valid    = 1'b0;
    logic [WIDTH-1:0] m_word     = '0;
    logic             m_over     = 1'b0;
    int               m_drops    = 0;

    function automatic logic [WIDTH-1:0] word_of(input entry_t e, input int idx);
        if (e.mode == 2'b01) return e.y;
        if ((e.mode == 2'b10) && (idx == 1)) return e.y;
        return e.x;
    endfunction

    function automatic int words_in(input entry_t e);
        return (e.mode == 2'b10) ? 2 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            q.delete();
            head_taken = 0;
            m_valid    = 1'b0;
            m_word     = '0;
            m_over     = 1'b0;
            m_drops    = 0;
        end else begin
            if (!m_valid || bus_ready) begin
                if (q.size() > 0) begin
                    m_word  = word_of(q[0], head_taken);
                    m_valid = 1'b1;
                    head_taken++;
                    if (head_taken == words_in(q[0])) begin
                        void'(q.pop_front());
                        head_taken = 0;
                    end
                end else begin
                    m_valid = 1'b0;
                    m_word  = '0;
                end
            end
            if (done) begin
                if (q.size() < DEPTH) begin
                    new_e.x    = x;
                    new_e.y    = y;
                    new_e.mode = mode;
                    q.push_back(new_e);
                end else begin
                    m_over = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    // Outputs settle after the rising edge; compare against the model on the falling edge
    always @(negedge clk) begin
        checkOutput("model_bus_valid", 32'(bus_valid), 32'(m_valid));
        checkOutput("model_bus_data", bus_data_out, m_word);
        checkOutput("model_fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
        checkOutput("model_overflow", 32'(overflow), 32'(m_over));
`ifdef CORDIC_OUT_DROPCNT_EN
        checkOutput("model_drop_count", 32'(drop_count), 32'(m_drops));
`endif
    end

    // Called at a falling edge; drives inputs for the next rising edge and returns at the following falling edge
    task automatic applyStimulus(input logic d, input logic [1:0] m, input logic [WIDTH-1:0] xv,
                                 input logic [WIDTH-1:0] yv, input logic r, input logic c);
        #1;
        done      = d;
        mode      = m;
        x         = xv;
        y         = yv;
        bus_ready = r;
        clear     = c;
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        applyStimulus(1'b0, 2'b00, '0, '0, r, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        done      = 1'b0;
        mode      = 2'b00;
        x         = '0;
        y         = '0;
        clear     = 1'b0;
        bus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(bus_valid), 32'd0);
        checkOutput("reset_data", bus_data_out, 32'd0);
        checkOutput("reset_full", 32'(fifo_full), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
`ifdef CORDIC_OUT_DROPCNT_EN
        checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Single mode-00 result with the bus ready
        applyStimulus(1'b1, 2'b00, 32'h00001234, 32'h0000BEEF, 1'b1, 1'b0);
        checkOutput("single_not_yet_valid", 32'(bus_valid), 32'd0);
        idle(1'b1);
        checkOutput("single_valid", 32'(bus_valid), 32'd1);
        checkOutput("single_data", bus_data_out, 32'h00001234);
        idle(1'b1);
        checkOutput("single_idle_valid", 32'(bus_valid), 32'd0);
        checkOutput("single_idle_data", bus_data_out, 32'd0);

        // Mode-10 pair streams X then Y back to back
        applyStimulus(1'b1, 2'b10, 32'h11111111, 32'hEEEEEEEE, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("pair_x_valid", 32'(bus_valid), 32'd1);
        checkOutput("pair_x_data", bus_data_out, 32'h11111111);
        idle(1'b1);
        checkOutput("pair_y_valid", 32'(bus_valid), 32'd1);
        checkOutput("pair_y_data", bus_data_out, 32'hEEEEEEEE);
        idle(1'b1);
        checkOutput("pair_done_valid", 32'(bus_valid), 32'd0);

        // Back-pressure: one word held on the bus, four results fill the FIFO, the fifth is dropped
        applyStimulus(1'b1, 2'b00, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("bp_held_data", bus_data_out, 32'hA5A5A5A5);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 2'b01, 32'hFFFF0000, 32'(i), 1'b0, 1'b0);
            checkOutput("bp_held_stable", bus_data_out, 32'hA5A5A5A5);
            checkOutput("bp_held_valid", 32'(bus_valid), 32'd1);
            if (i == 4) begin
                checkOutput("bp_full_after_4", 32'(fifo_full), 32'd1);
                checkOutput("bp_no_overflow_yet", 32'(overflow), 32'd0);
            end
        end
        checkOutput("bp_overflow", 32'(overflow), 32'd1);
`ifdef CORDIC_OUT_DROPCNT_EN
        checkOutput("bp_drop_count", 32'(drop_count), 32'd1);
`endif
        idle(1'b0);
        checkOutput("bp_still_held", bus_data_out, 32'hA5A5A5A5);
        for (int i = 1; i <= 4; i++) begin
            idle(1'b1);
            checkOutput("bp_drain_data", bus_data_out, 32'(i));
            checkOutput("bp_drain_valid", 32'(bus_valid), 32'd1);
        end
        idle(1'b1);
        checkOutput("bp_fifth_absent", 32'(bus_valid), 32'd0);

        // Full FIFO with a pop and a done on the same edge keeps the count at DEPTH
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
        checkOutput("clear_overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 2'b00, 32'h000000B0, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 2'b11, 32'(32'hB0 + i), 32'h0, 1'b0, 1'b0);
        end
        checkOutput("fpd_full_before", 32'(fifo_full), 32'd1);
        applyStimulus(1'b1, 2'b00, 32'h000000B5, 32'h0, 1'b1, 1'b0);
        checkOutput("fpd_full_after", 32'(fifo_full), 32'd1);
        checkOutput("fpd_no_overflow", 32'(overflow), 32'd0);
        checkOutput("fpd_data", bus_data_out, 32'h000000B1);
        for (int i = 2; i <= 5; i++) begin
            idle(1'b1);
            checkOutput("fpd_drain_data", bus_data_out, 32'(32'hB0 + i));
        end
        idle(1'b1);
        checkOutput("fpd_drain_end", 32'(bus_valid), 32'd0);

        // Clear while the X half of a pair is stalled, with a competing done
        applyStimulus(1'b1, 2'b10, 32'h11111111, 32'hEEEEEEEE, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 32'h000000C0, 32'h0, 1'b0, 1'b0);
        checkOutput("clr_pair_x_held", bus_data_out, 32'h11111111);
        applyStimulus(1'b1, 2'b00, 32'h0000DEAD, 32'h0, 1'b1, 1'b1);
        checkOutput("clr_valid", 32'(bus_valid), 32'd0);
        checkOutput("clr_data", bus_data_out, 32'd0);
        checkOutput("clr_full", 32'(fifo_full), 32'd0);
        checkOutput("clr_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkOutput("clr_nothing_emitted", 32'(bus_valid), 32'd0);
        end

        // Randomized traffic at several consumer duty cycles
        for (int seg = 0; seg < 6; seg++) begin
            int ready_pct;
            ready_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 55 : 90);
            for (int n = 0; n < 500; n++) begin
                applyStimulus(($urandom_range(0, 99) < 45),
                              2'($urandom_range(0, 3)),
                              $urandom, $urandom,
                              ($urandom_range(0, 99) < ready_pct),
                              ($urandom_range(0, 199) == 0));
            end
        end

        // Asynchronous reset between edges while a word is on the bus
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b00, 32'h00005A5A, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("areset_pre_valid", 32'(bus_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_valid", 32'(bus_valid), 32'd0);
        checkOutput("areset_data", bus_data_out, 32'd0);
        checkOutput("areset_full", 32'(fifo_full), 32'd0);
        checkOutput("areset_overflow", 32'(overflow), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        idle(1'b1);
        checkOutput("areset_stays_idle", 32'(bus_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
